// File: rtl/bht_ctrl_if.sv
// Fetch-lookup and execute-update bus of the branch history table controller.
// STAT_W must match the STAT_W of the bht_ctrl instance this bus is attached to.
interface bht_ctrl_if #(
    parameter int STAT_W = 32
);
    logic [63:0]       lk_pc;
    logic [31:0]       lk_ir;
    logic              pr_taken;
    logic [12:0]       pr_offs;
    logic              ready;
    logic              upd_valid;
    logic [63:0]       upd_pc;
    logic              upd_taken;
    logic              upd_pred;
    logic [STAT_W-1:0] br_cnt;
    logic [STAT_W-1:0] mp_cnt;

    modport master (
        output lk_pc, lk_ir, upd_valid, upd_pc, upd_taken, upd_pred,
        input  pr_taken, pr_offs, ready, br_cnt, mp_cnt
    );

    modport slave (
        input  lk_pc, lk_ir, upd_valid, upd_pc, upd_taken, upd_pred,
        output pr_taken, pr_offs, ready, br_cnt, mp_cnt
    );
endinterface

// File: rtl/bht_ctrl.sv
// Direct-mapped table of 2-bit saturating branch counters. Lookups are
// combinational; resolved updates land one cycle later through a bypassed stage.
module bht_ctrl #(
    parameter int         IDX_W    = 6,
    parameter logic [1:0] CNT_INIT = 2'b01,
    parameter int         STAT_W   = 32
) (
    input logic         clk,
    input logic         rst,
    input logic         flush,
    bht_ctrl_if.slave   bus
);
    localparam int N = 2 ** IDX_W;

    typedef enum logic {S_INIT, S_RUN} state_e;

    state_e            state_q;
    logic [IDX_W-1:0]  init_idx_q;
    logic              ready_q;
    logic [1:0]        tbl_q [N];
    logic              stg_vld_q;
    logic [IDX_W-1:0]  stg_idx_q;
    logic [1:0]        stg_val_q;
    logic [STAT_W-1:0] br_q, br_d;
    logic [STAT_W-1:0] mp_q, mp_d;

    logic [IDX_W-1:0]  lk_idx, up_idx, tbl_widx;
    logic [1:0]        lk_ctr, up_base, up_new, tbl_wval;
    logic              acc, tbl_we;

    function automatic logic [1:0] sat_step(input logic [1:0] c, input logic t);
        if (t) return (c == 2'b11) ? c : c + 2'b01;
        else   return (c == 2'b00) ? c : c - 2'b01;
    endfunction

    assign lk_idx = bus.lk_pc[IDX_W+1:2];
    assign up_idx = bus.upd_pc[IDX_W+1:2];

    // The staged value is newer than the table entry it will overwrite.
    assign lk_ctr  = (stg_vld_q && stg_idx_q == lk_idx) ? stg_val_q : tbl_q[lk_idx];
    assign up_base = (stg_vld_q && stg_idx_q == up_idx) ? stg_val_q : tbl_q[up_idx];
    assign up_new  = sat_step(up_base, bus.upd_taken);

    // An update coinciding with flush is dropped along with the stage.
    assign acc  = (state_q == S_RUN) && bus.upd_valid && !flush;
    assign br_d = (acc && br_q != '1) ? br_q + STAT_W'(1) : br_q;
    assign mp_d = (acc && (bus.upd_taken != bus.upd_pred) && mp_q != '1)
                  ? mp_q + STAT_W'(1) : mp_q;

    assign tbl_we   = !rst && !flush && (state_q == S_INIT || stg_vld_q);
    assign tbl_widx = (state_q == S_INIT) ? init_idx_q : stg_idx_q;
    assign tbl_wval = (state_q == S_INIT) ? CNT_INIT : stg_val_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_INIT;
            init_idx_q <= '0;
            ready_q    <= 1'b0;
            stg_vld_q  <= 1'b0;
            stg_idx_q  <= '0;
            stg_val_q  <= 2'b00;
            br_q       <= '0;
            mp_q       <= '0;
        end else if (flush) begin
            state_q    <= S_INIT;
            init_idx_q <= '0;
            ready_q    <= 1'b0;
            stg_vld_q  <= 1'b0;
        end else begin
            case (state_q)
                S_INIT: begin
                    stg_vld_q  <= 1'b0;
                    init_idx_q <= init_idx_q + IDX_W'(1);
                    if (init_idx_q == IDX_W'(N - 1)) begin
                        state_q <= S_RUN;
                        ready_q <= 1'b1;
                    end
                end
                S_RUN: begin
                    stg_vld_q <= acc;
                    if (acc) begin
                        stg_idx_q <= up_idx;
                        stg_val_q <= up_new;
                    end
                    br_q <= br_d;
                    mp_q <= mp_d;
                end
                default: state_q <= S_INIT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (tbl_we) tbl_q[tbl_widx] <= tbl_wval;
    end

    assign bus.pr_taken = ready_q & (bus.lk_ir[6:0] == 7'b1100011) & lk_ctr[1];
    assign bus.pr_offs  = {bus.lk_ir[31], bus.lk_ir[7], bus.lk_ir[30:25], bus.lk_ir[11:8], 1'b0};
    assign bus.ready    = ready_q;
    assign bus.br_cnt   = br_q;
    assign bus.mp_cnt   = mp_q;

    logic unused_bits;
    assign unused_bits = ^{bus.lk_pc[63:IDX_W+2], bus.lk_pc[1:0], bus.lk_ir[24:12],
                           bus.upd_pc[63:IDX_W+2], bus.upd_pc[1:0]};
endmodule

// File: tb/tb_bht_ctrl.sv
// Directed bench for bht_ctrl: stimulus pushes expectations, a negedge monitor checks them.
module tb_bht_ctrl;
    logic clk = 1'b0;
    logic rst, flush, flush3;
    always #5 clk = ~clk;

    bht_ctrl_if #(.STAT_W(32)) bi ();
    bht_ctrl_if #(.STAT_W(3))  bi3 ();

    bht_ctrl #(.IDX_W(6), .CNT_INIT(2'b01), .STAT_W(32)) u_dut (
        .clk(clk), .rst(rst), .flush(flush), .bus(bi));
    bht_ctrl #(.IDX_W(6), .CNT_INIT(2'b01), .STAT_W(3)) u_dut3 (
        .clk(clk), .rst(rst), .flush(flush3), .bus(bi3));

    localparam int K_PR = 0, K_RDY = 1, K_OFF = 2, K_BR = 3, K_MP = 4;
    localparam int K3_PR = 5, K3_RDY = 6, K3_BR = 7, K3_MP = 8;

    typedef struct {
        int          kind;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;
    int   br_e = 0;
    int   mp_e = 0;

    task automatic push_exp(input int kind, input logic [31:0] v, input string nm);
        exp_t e;
        e.kind = kind; e.val = v; e.name = nm;
        sbq.push_back(e);
    endtask

    // Outputs are settled mid-cycle; drain everything queued for this cycle.
    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] act;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            case (e.kind)
                K_PR:    act = 32'(bi.pr_taken);
                K_RDY:   act = 32'(bi.ready);
                K_OFF:   act = 32'(bi.pr_offs);
                K_BR:    act = bi.br_cnt;
                K_MP:    act = bi.mp_cnt;
                K3_PR:   act = 32'(bi3.pr_taken);
                K3_RDY:  act = 32'(bi3.ready);
                K3_BR:   act = 32'(bi3.br_cnt);
                K3_MP:   act = 32'(bi3.mp_cnt);
                default: act = 32'hdead_beef;
            endcase
            checks++;
            if (act !== e.val) begin
                errors++;
                $display("FAIL %s: got %0h expected %0h", e.name, act, e.val);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bi.upd_valid = 1'b0;
    endtask

    task automatic upd(input logic [63:0] pc, input logic t, input logic p, input bit cnt);
        bi.upd_valid = 1'b1; bi.upd_pc = pc; bi.upd_taken = t; bi.upd_pred = p;
        if (cnt) begin
            br_e++;
            if (t != p) mp_e++;
        end
    endtask

    task automatic look(input logic [63:0] pc, input logic [31:0] ir, input logic exp, input string nm);
        bi.lk_pc = pc; bi.lk_ir = ir;
        push_exp(K_PR, 32'(exp), nm);
    endtask

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        rst = 1'b1; flush = 1'b0; flush3 = 1'b0;
        bi.lk_pc = '0; bi.lk_ir = 32'h63; bi.upd_valid = 0; bi.upd_pc = '0;
        bi.upd_taken = 0; bi.upd_pred = 0;
        bi3.lk_pc = '0; bi3.lk_ir = 32'h63; bi3.upd_valid = 0; bi3.upd_pc = '0;
        bi3.upd_taken = 0; bi3.upd_pred = 0;
        step();
        rst = 1'b0;
        push_exp(K_BR, 0, "rst_br");
        push_exp(K_MP, 0, "rst_mp");
        push_exp(K_OFF, 0, "rst_offs");
        push_exp(K3_RDY, 0, "rst_rdy3");
        for (int i = 0; i < 64; i++) begin
            look(64'(i * 4), 32'h63, 1'b0, "init_pr");
            push_exp(K_RDY, 0, "init_rdy");
            step();
        end
        push_exp(K_RDY, 1, "init_done");
        push_exp(K3_RDY, 1, "init_done3");
        look(64'h0, 32'h63, 1'b0, "weak_nt_0");
        step();
        look(64'h104, 32'hFE000EE3, 1'b0, "weak_nt_104");
        push_exp(K_OFF, 32'h1FFC, "offs_neg4");
        step();
        bi.lk_ir = 32'h80000F6F;
        push_exp(K_OFF, 32'h101E, "offs_nonbr");
        step();

        // single update then bypassed lookup and alias at +4*2**IDX_W
        upd(64'h100, 1, 0, 1);
        look(64'h100, 32'h63, 1'b0, "pre_update");
        step(); idle();
        look(64'h100, 32'h63, 1'b1, "bypass");
        step();
        look(64'h200, 32'h63, 1'b1, "alias");
        step();

        upd(64'h100, 1, 1, 1); step();
        upd(64'h100, 1, 1, 1); step(); idle();
        look(64'h100, 32'h63, 1'b1, "trained");
        step();
        look(64'h104, 32'h63, 1'b0, "neighbour");
        step();
        look(64'h100, 32'h6F, 1'b0, "jal_main");
        step();

        // hysteresis: counter 3 stays 3, then 2, then back-to-back NT to 0
        for (int i = 0; i < 4; i++) begin
            upd(64'h200, 1, 1, 1); step();
        end
        upd(64'h200, 0, 1, 1); step(); idle();
        look(64'h200, 32'h63, 1'b1, "hyst_keep");
        step();
        upd(64'h200, 0, 1, 1); step();
        upd(64'h200, 0, 1, 1); step(); idle();
        look(64'h200, 32'h63, 1'b0, "hyst_flip");
        step();
        upd(64'h200, 1, 0, 1); step(); idle();
        look(64'h200, 32'h63, 1'b0, "hyst_floor");
        step();

        // train then flush with the second write still staged
        upd(64'h100, 1, 1, 1); step();
        upd(64'h100, 1, 1, 1); step(); idle();
        look(64'h100, 32'h63, 1'b1, "pre_flush");
        push_exp(K_BR, 13, "br_total");
        push_exp(K_MP, 5, "mp_total");
        flush = 1'b1;
        step();
        flush = 1'b0;
        for (int i = 0; i < 64; i++) begin
            push_exp(K_RDY, 0, "flush_rdy");
            look(64'h100, 32'h63, 1'b0, "flush_pr");
            upd(64'h100, 1, 0, 0);
            if (i % 16 == 0) begin
                push_exp(K_BR, 32'(br_e), "flush_br");
                push_exp(K_MP, 32'(mp_e), "flush_mp");
            end
            step();
        end
        idle();
        push_exp(K_RDY, 1, "flush_done");
        look(64'h100, 32'h63, 1'b0, "post_flush");
        push_exp(K_BR, 13, "post_flush_br");
        push_exp(K_MP, 5, "post_flush_mp");
        step();

        // narrow statistics saturate at 7
        for (int i = 0; i < 9; i++) begin
            bi3.upd_valid = 1; bi3.upd_pc = 64'h100; bi3.upd_taken = 1; bi3.upd_pred = 0;
            if (i == 3) push_exp(K3_BR, 3, "sat_mid");
            step();
        end
        bi3.upd_valid = 0;
        for (int i = 0; i < 3; i++) begin
            push_exp(K3_BR, 7, "sat_br");
            push_exp(K3_MP, 7, "sat_mp");
            step();
        end
        bi3.lk_pc = 64'h100; bi3.lk_ir = 32'h6F;
        push_exp(K3_PR, 0, "jal3");
        step();
        bi3.lk_ir = 32'h63;
        push_exp(K3_PR, 1, "br3");
        step();
        step();
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sbq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
